// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared defaults, register-address type and zero-register helper
package regfile_mp_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_AW = $clog2(DEF_NUM_REGS);
  typedef logic [DEF_AW-1:0] reg_addr_t;
  localparam reg_addr_t ZERO_ADDR = '0;
  function automatic logic is_live(input int addr, input logic zero_reg);
    return !(zero_reg && addr == int'(ZERO_ADDR));
  endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: issue/writeback/read bundle between pipeline (master) and register file (slave)
interface regfile_mp_if import regfile_mp_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2,
  parameter int AW = $clog2(NUM_REGS)
);
  logic [NUM_WR-1:0] wr_en;
  logic [NUM_WR-1:0][AW-1:0] wr_addr;
  logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
  logic [NUM_RD-1:0][AW-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0] rd_busy;
  logic [NUM_WR-1:0] iss_en;
  logic [NUM_WR-1:0][AW-1:0] iss_addr;
  logic iss_ready;
  logic sb_err;
  modport master(output wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr,
                 input rd_data, rd_busy, iss_ready, sb_err);
  modport slave(input wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr,
                output rd_data, rd_busy, iss_ready, sb_err);
endinterface

// File: rtl/regfile_mp_rf_scoreboard.sv
// rf_scoreboard: per-register pending-write counters with all-or-nothing reservation,
// release-aware busy flags and a sticky underflow error
module rf_scoreboard import regfile_mp_pkg::*; #(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2,
  parameter int CNT_W = 2,
  parameter int ZERO_REG = 1,
  parameter int AW = $clog2(NUM_REGS)
)(
  input  logic clk,
  input  logic rst,
  input  logic [NUM_WR-1:0] i_wr_en,
  input  logic [NUM_WR-1:0][AW-1:0] i_wr_addr,
  input  logic [NUM_WR-1:0] i_iss_en,
  input  logic [NUM_WR-1:0][AW-1:0] i_iss_addr,
  input  logic [NUM_RD-1:0][AW-1:0] i_rd_addr,
  output logic [NUM_RD-1:0] o_rd_busy,
  output logic o_iss_ready,
  output logic o_sb_err
);
  localparam int SW = CNT_W + $clog2(NUM_WR + 1) + 2;
  typedef logic signed [SW-1:0] sc_t;
  localparam sc_t ONE = sc_t'(1);
  localparam sc_t ZERO_C = sc_t'(0);
  localparam sc_t MAX_C = sc_t'((1 << CNT_W) - 1);
  logic [CNT_W-1:0] r_cnt [NUM_REGS];
  logic r_sb_err;
  sc_t w_held [NUM_REGS];
  sc_t w_sum [NUM_REGS];
  sc_t w_val [NUM_REGS];
  logic [NUM_REGS-1:0] w_ovf, w_under;
  // held = count after this cycle's releases (may go negative on underflow); sum adds reservations
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_held[r] = sc_t'(r_cnt[r]);
      for (int p = 0; p < NUM_WR; p++)
        if (i_wr_en[p] && i_wr_addr[p] == AW'(r) && is_live(r, ZERO_REG != 0)) w_held[r] = w_held[r] - ONE;
      w_sum[r] = w_held[r];
      for (int p = 0; p < NUM_WR; p++)
        if (i_iss_en[p] && i_iss_addr[p] == AW'(r) && is_live(r, ZERO_REG != 0)) w_sum[r] = w_sum[r] + ONE;
      w_ovf[r] = w_sum[r] > MAX_C;
      w_under[r] = w_held[r] < ZERO_C;
    end
    o_iss_ready = ~|w_ovf;
    for (int r = 0; r < NUM_REGS; r++) w_val[r] = o_iss_ready ? w_sum[r] : w_held[r];
    o_rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) o_rd_busy[i] = w_held[i_rd_addr[i]] > ZERO_C;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
      r_sb_err <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= w_val[r] < ZERO_C ? '0 : CNT_W'(w_val[r]);
      r_sb_err <= r_sb_err | (|w_under);
    end
  end
  assign o_sb_err = r_sb_err;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-first bypass and integrated
// pending-write scoreboard for the dual-issue pipeline
module regfile_mp import regfile_mp_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2,
  parameter int CNT_W = 2,
  parameter int ZERO_REG = 1
)(
  input logic clk,
  input logic rst,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [NUM_RD-1:0][DATA_W-1:0] w_rd;
  // later ports are applied last, so the highest index wins on address collisions
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++)
        if (bus.wr_en[p] && is_live(int'(bus.wr_addr[p]), ZERO_REG != 0)) r_regs[bus.wr_addr[p]] <= bus.wr_data[p];
    end
  end
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_rd[i] = r_regs[bus.rd_addr[i]];
      for (int p = 0; p < NUM_WR; p++)
        if (bus.wr_en[p] && bus.wr_addr[p] == bus.rd_addr[i]) w_rd[i] = bus.wr_data[p];
      if (!is_live(int'(bus.rd_addr[i]), ZERO_REG != 0)) w_rd[i] = '0;
    end
  end
  assign bus.rd_data = w_rd;
  rf_scoreboard #(
    .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
    .CNT_W(CNT_W), .ZERO_REG(ZERO_REG), .AW(AW)
  ) u_sb (
    .clk(clk),
    .rst(rst),
    .i_wr_en(bus.wr_en),
    .i_wr_addr(bus.wr_addr),
    .i_iss_en(bus.iss_en),
    .i_iss_addr(bus.iss_addr),
    .i_rd_addr(bus.rd_addr),
    .o_rd_busy(bus.rd_busy),
    .o_iss_ready(bus.iss_ready),
    .o_sb_err(bus.sb_err)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random stimulus checked against an integer reference
// model of register contents and pending-write counts
module tb_regfile_mp;
  localparam int DW = 32, NR = 32, NRD = 4, NWR = 2, CW = 2, AW = 5;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] m_regs [NR];
  int m_cnt [NR];
  bit m_err;
  regfile_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) bus();
  regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .CNT_W(CW), .ZERO_REG(1))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic idle();
    bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.iss_en = '0; bus.iss_addr = '0;
  endtask
  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin m_regs[r] = '0; m_cnt[r] = 0; end
    m_err = 0;
  endtask
  task automatic step();
    int rel [NR];
    int iss [NR];
    bit ready;
    #1;
    for (int r = 0; r < NR; r++) begin rel[r] = 0; iss[r] = 0; end
    for (int p = 0; p < NWR; p++) begin
      if (bus.wr_en[p] && bus.wr_addr[p] != 0) rel[bus.wr_addr[p]]++;
      if (bus.iss_en[p] && bus.iss_addr[p] != 0) iss[bus.iss_addr[p]]++;
    end
    ready = 1;
    for (int r = 0; r < NR; r++) if (m_cnt[r] - rel[r] + iss[r] > MAXC) ready = 0;
    for (int i = 0; i < NRD; i++) begin
      automatic int a = int'(bus.rd_addr[i]);
      automatic logic [DW-1:0] exp = m_regs[a];
      for (int p = 0; p < NWR; p++) if (bus.wr_en[p] && int'(bus.wr_addr[p]) == a) exp = bus.wr_data[p];
      if (a == 0) exp = '0;
      chk($sformatf("rd_data[%0d] r%0d", i, a), bus.rd_data[i], exp);
      chk($sformatf("rd_busy[%0d] r%0d", i, a), bus.rd_busy[i], (a != 0) && (m_cnt[a] - rel[a] > 0));
    end
    chk("iss_ready", bus.iss_ready, ready);
    chk("sb_err", bus.sb_err, m_err);
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      for (int p = 0; p < NWR; p++) if (bus.wr_en[p] && bus.wr_addr[p] != 0) m_regs[bus.wr_addr[p]] = bus.wr_data[p];
      for (int r = 0; r < NR; r++) begin
        if (rel[r] > m_cnt[r]) m_err = 1;
        m_cnt[r] = m_cnt[r] + (ready ? iss[r] : 0) - rel[r];
        if (m_cnt[r] < 0) m_cnt[r] = 0;
      end
    end
    @(negedge clk);
  endtask
  task automatic wr(input int p, input int a, input logic [DW-1:0] d);
    bus.wr_en[p] = 1'b1; bus.wr_addr[p] = AW'(a); bus.wr_data[p] = d;
  endtask
  task automatic is(input int p, input int a);
    bus.iss_en[p] = 1'b1; bus.iss_addr[p] = AW'(a);
  endtask
  initial begin
    idle();
    bus.rd_addr = '0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    for (int i = 0; i < NRD; i++) bus.rd_addr[i] = AW'(i * 5 + 1);
    step();
    rst = 1'b1;
    wr(0, 5, 32'h1234_5678); bus.rd_addr[0] = 5; step();
    idle(); step();
    wr(0, 7, 32'hAAAA_AAAA); wr(1, 7, 32'h5555_5555); bus.rd_addr[1] = 7; step();
    idle(); step();
    rst = 1'b0; step(); rst = 1'b1;
    wr(0, 0, 32'hFFFF_FFFF); is(1, 0); bus.rd_addr[2] = 0; step();
    idle(); step();
    bus.rd_addr[0] = 3;
    for (int k = 0; k < 4; k++) begin idle(); is(0, 3); step(); end
    for (int k = 0; k < 3; k++) begin idle(); wr(1, 3, $urandom); step(); end
    idle(); step();
    bus.rd_addr[1] = 9;
    is(0, 9); step();
    idle(); is(1, 9); wr(0, 9, 32'hCAFE_0009); step();
    idle(); step();
    bus.rd_addr[2] = 4;
    wr(1, 4, 32'h0000_0444); step();
    idle(); is(0, 12); is(1, 13); step();
    idle(); step();
    rst = 1'b0; step();
    rst = 1'b1; bus.rd_addr[3] = 12; step();
    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(0, 60) != 0);
      for (int p = 0; p < NWR; p++) begin
        if ($urandom_range(0, 2) == 0) wr(p, $urandom_range(0, 7), $urandom);
        if ($urandom_range(0, 1) == 0) is(p, $urandom_range(0, 7));
      end
      for (int i = 0; i < NRD; i++) bus.rd_addr[i] = AW'($urandom_range(0, 8));
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
